// File: rtl/mips_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_lsu_if
// Brief    : Core-side request/response bundle of the MIPS load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LANES      = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [8*LANES-1:0]    req_wdata;
    logic                  resp_valid;
    logic [8*LANES-1:0]    resp_rdata;
    logic                  resp_fault;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, busy
    );
endinterface
`default_nettype wire

// File: rtl/mips_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mips_lsu
// Brief    : Load/store unit with sub-word read-modify-write and alignment faults.
// Revision : 1.0 - initial release
// ============================================================================
module mips_lsu #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    mips_lsu_if.slave             core,
    // Memory words are flat vectors with lane 0 in the most significant byte.
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [8*LANES-1:0]    mem_data_in,
    input  logic [8*LANES-1:0]    mem_data_out,
    output logic                  mem_write_en
);
    localparam int c_off_w  = $clog2(LANES);
    localparam int c_data_w = 8 * LANES;
    localparam int c_cnt_w  = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_write;
    logic [1:0]           r_size;
    logic                 r_signed;
    logic [c_off_w-1:0]   r_off;
    logic [15:0]          r_wdata;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_accept;
    logic                 w_fault;
    logic [c_data_w-1:0]  w_shift;
    logic [c_data_w-1:0]  w_load;
    logic [c_data_w-1:0]  w_merged;

    assign core.req_ready = (r_state == S_IDLE);
    assign core.busy      = (r_state != S_IDLE);
    assign w_accept       = core.req_valid && (r_state == S_IDLE);

    always_comb begin
        w_fault = 1'b0;
        case (core.req_size)
            2'd1:    w_fault = core.req_addr[0];
            2'd2:    w_fault = (core.req_addr[c_off_w-1:0] != '0);
            2'd3:    w_fault = 1'b1;
            default: w_fault = 1'b0;
        endcase
    end

    // Shifting the addressed lane up to the MSB makes the extract independent of the offset.
    always_comb begin
        w_shift = mem_data_out << {r_off, 3'b000};
        case (r_size)
            2'd0:    w_load = {{(c_data_w-8){r_signed & w_shift[c_data_w-1]}},
                               w_shift[c_data_w-1 -: 8]};
            2'd1:    w_load = {{(c_data_w-16){r_signed & w_shift[c_data_w-1]}},
                               w_shift[c_data_w-1 -: 16]};
            default: w_load = w_shift;
        endcase
    end

    // Halves are always even-aligned here, so their low byte sits in the odd lane off+1.
    always_comb begin
        w_merged = mem_data_out;
        for (int i = 0; i < LANES; i++) begin
            if (r_size == 2'd0 && r_off == c_off_w'(i))
                w_merged[c_data_w-1-8*i -: 8] = r_wdata[7:0];
            else if (r_size == 2'd1 && r_off == c_off_w'(i))
                w_merged[c_data_w-1-8*i -: 8] = r_wdata[15:8];
            else if (r_size == 2'd1 && (i % 2 == 1) && r_off == c_off_w'(i - 1))
                w_merged[c_data_w-1-8*i -: 8] = r_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state         <= S_IDLE;
            r_write         <= 1'b0;
            r_size          <= 2'd0;
            r_signed        <= 1'b0;
            r_off           <= '0;
            r_wdata         <= '0;
            r_cnt           <= '0;
            mem_addr        <= '0;
            mem_data_in     <= '0;
            mem_write_en    <= 1'b0;
            core.resp_valid <= 1'b0;
            core.resp_fault <= 1'b0;
            core.resp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write  <= core.req_write;
                        r_size   <= core.req_size;
                        r_signed <= core.req_signed;
                        r_off    <= core.req_addr[c_off_w-1:0];
                        r_wdata  <= core.req_wdata[15:0];
                        mem_addr <= {core.req_addr[ADDR_WIDTH-1:c_off_w], {c_off_w{1'b0}}};
                        if (w_fault) begin
                            core.resp_valid <= 1'b1;
                            core.resp_fault <= 1'b1;
                            core.resp_rdata <= '0;
                            r_state         <= S_RESP;
                        end else if (!core.req_write || core.req_size != 2'd2) begin
                            r_cnt   <= c_cnt_w'(MEM_LATENCY);
                            r_state <= S_READ;
                        end else begin
                            mem_data_in  <= core.req_wdata;
                            mem_write_en <= 1'b1;
                            r_state      <= S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    if (r_cnt == c_cnt_w'(1)) begin
                        if (r_write) begin
                            mem_data_in  <= w_merged;
                            mem_write_en <= 1'b1;
                            r_state      <= S_WRITE;
                        end else begin
                            core.resp_valid <= 1'b1;
                            core.resp_rdata <= w_load;
                            r_state         <= S_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    mem_write_en    <= 1'b0;
                    core.resp_valid <= 1'b1;
                    core.resp_rdata <= '0;
                    r_state         <= S_RESP;
                end
                S_RESP: begin
                    core.resp_valid <= 1'b0;
                    core.resp_fault <= 1'b0;
                    core.resp_rdata <= '0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_lsu
// Brief    : Randomized bench for mips_lsu at three geometries against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_lsu;
    localparam int NDUT = 3;

    function automatic int lanes_of(input int d);
        return (d == 2) ? 8 : 4;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]        rv, rw, rsg, rr, respv, respf, bsy, mwe, pl_en;
    logic [NDUT-1:0][1:0]   rsz;
    logic [NDUT-1:0][31:0]  raddr, maddr;
    logic [NDUT-1:0][63:0]  rwd, rdata, mdin;
    logic [63:0]            init_word [NDUT][64];
    logic [7:0]             mb [NDUT][256];
    int                     n_tests = 0;
    int                     n_fail  = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LN = lanes_of(g);
        localparam int LT = lat_of(g);
        localparam int DW = 8 * LN;
        localparam int OW = $clog2(LN);
        logic [DW-1:0] mdi, mdo;
        logic [31:0]   ma, rd_a;
        logic [63:0]   mem [64];
        logic [31:0]   apipe [4];

        mips_lsu_if #(.ADDR_WIDTH(32), .LANES(LN)) bus ();
        assign bus.req_valid  = rv[g];
        assign bus.req_write  = rw[g];
        assign bus.req_size   = rsz[g];
        assign bus.req_signed = rsg[g];
        assign bus.req_addr   = raddr[g];
        assign bus.req_wdata  = rwd[g][DW-1:0];
        assign rr[g]    = bus.req_ready;
        assign respv[g] = bus.resp_valid;
        assign respf[g] = bus.resp_fault;
        assign bsy[g]   = bus.busy;
        assign rdata[g] = 64'(bus.resp_rdata);
        assign maddr[g] = ma;
        assign mdin[g]  = 64'(mdi);

        mips_lsu #(.ADDR_WIDTH(32), .LANES(LN), .MEM_LATENCY(LT)) dut (
            .clk          (clk),
            .rst_b        (rst_b),
            .core         (bus),
            .mem_addr     (ma),
            .mem_data_in  (mdi),
            .mem_data_out (mdo),
            .mem_write_en (mwe[g])
        );

        // Read data only reflects an address after it has been stable LT cycles.
        always @(posedge clk) begin
            apipe[0] <= ma;
            for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
        end
        assign rd_a = (LT == 1) ? ma : apipe[(LT >= 2) ? LT - 2 : 0];
        assign mdo  = DW'(mem[6'(rd_a >> OW)]);

        always @(posedge clk) begin
            if (pl_en[g]) begin
                for (int w = 0; w < 64; w++) mem[w] <= init_word[g][w];
            end else if (mwe[g]) begin
                mem[6'(ma >> OW)] <= 64'(mdi);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input int d, input int w);
        case (d)
            0:       return g_dut[0].mem[w];
            1:       return g_dut[1].mem[w];
            default: return g_dut[2].mem[w];
        endcase
    endfunction

    function automatic logic [63:0] model_word(input int d, input int w);
        logic [63:0] v = '0;
        for (int k = 0; k < lanes_of(d); k++) v = (v << 8) | 64'(mb[d][8'(w * lanes_of(d) + k)]);
        return v;
    endfunction

    function automatic int nbytes(input int d, input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : lanes_of(d));
    endfunction

    // Big-endian: the lowest address is the most significant byte of the result.
    function automatic logic [63:0] model_load(input int d, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sg);
        int n = nbytes(d, sz);
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 64'(mb[d][8'(a + 32'(k))]);
        if (sg && n < lanes_of(d) && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        if (lanes_of(d) == 4) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic do_txn(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [63:0] wd, input bit hold,
                          output logic [63:0] got);
        int          n   = nbytes(d, sz);
        bit          flt = (sz == 2'd3) || ((a % 32'(n)) != 0);
        int          exp_lat;
        logic [63:0] exp_rd = '0;
        int          wpulses = 0;
        int          cyc = 0;
        bit          seen = 0;
        bit          bad = 0;
        if (!flt && !wr) exp_rd = model_load(d, a, sz, sg);
        exp_lat = flt ? 1 : (!wr ? lat_of(d) + 1 : ((n == lanes_of(d)) ? 2 : lat_of(d) + 2));
        got = '0;

        @(negedge clk);
        rv[d] = 1'b1; rw[d] = wr; rsz[d] = sz; rsg[d] = sg; raddr[d] = a; rwd[d] = wd;
        check("ready", 64'(rr[d]), 64'd1);
        @(posedge clk);
        while (1) begin
            #1;
            cyc++;
            if (mwe[d]) wpulses++;
            if (!bsy[d] || rr[d]) bad = 1;
            if (respv[d]) begin
                seen = 1;
                got  = rdata[d];
                check("fault", 64'(respf[d]), 64'(flt));
                break;
            end
            if (cyc >= 20) break;
            // Garbage requests while busy must be ignored.
            @(negedge clk);
            rw[d] = 1'($urandom); rsz[d] = 2'($urandom); rsg[d] = 1'($urandom);
            raddr[d] = $urandom; rwd[d] = {$urandom, $urandom};
            @(posedge clk);
        end
        if (!hold) rv[d] = 1'b0;
        check("resp_seen", 64'(seen), 64'd1);
        check("latency", 64'(cyc), 64'(exp_lat));
        check("rdata", got, exp_rd);
        check("wr_pulses", 64'(wpulses), 64'((wr && !flt) ? 1 : 0));
        check("busy_ready", 64'(bad), 64'd0);
        if (wr && !flt)
            for (int k = 0; k < n; k++) mb[d][8'(a + 32'(k))] = wd[8*(n-1-k) +: 8];
        check("mem", mem_word(d, int'(a) / lanes_of(d)), model_word(d, int'(a) / lanes_of(d)));
        if (!hold) begin
            @(posedge clk); #1;
            check("idle", 64'({respv[d], rr[d], bsy[d]}), 64'(3'b010));
        end
    endtask

    initial begin
        logic [63:0] got;
        int          cyc;
        int          pulses;
        rv = '0; rw = '0; rsg = '0; rsz = '0; raddr = '0; rwd = '0; pl_en = '0;
        for (int d = 0; d < NDUT; d++)
            for (int w = 0; w < 64; w++) begin
                init_word[d][w] = {$urandom, $urandom};
                if (lanes_of(d) == 4) init_word[d][w][63:32] = '0;
            end
        init_word[0][16] = 64'h1122_3384;
        init_word[1][16] = 64'hFFEE_0000;
        for (int d = 0; d < NDUT; d++)
            for (int b = 0; b < 256; b++)
                mb[d][b] = init_word[d][b / lanes_of(d)][8*(lanes_of(d)-1-(b % lanes_of(d))) +: 8];

        @(negedge clk); pl_en = '1;
        @(negedge clk); pl_en = '0;
        for (int d = 0; d < NDUT; d++) begin
            check("rst_ctl", 64'({rr[d], bsy[d], respv[d], respf[d], mwe[d]}), 64'(5'b10000));
            check("rst_rdata", rdata[d], 64'd0);
            check("rst_maddr", 64'(maddr[d]), 64'd0);
        end
        rst_b = 1'b1;

        // Byte loads with sign/zero extension, then sub-word read-modify-write.
        do_txn(0, 1'b0, 2'd0, 1'b1, 32'h43, 64'd0, 1'b0, got); check("t1_lb43", got, 64'hFFFF_FF84);
        do_txn(0, 1'b0, 2'd0, 1'b0, 32'h43, 64'd0, 1'b0, got); check("t1_lbu43", got, 64'h0000_0084);
        do_txn(0, 1'b0, 2'd0, 1'b1, 32'h40, 64'd0, 1'b0, got); check("t1_lb40", got, 64'h0000_0011);
        do_txn(0, 1'b1, 2'd2, 1'b0, 32'h40, 64'h1122_3344, 1'b0, got);
        do_txn(0, 1'b1, 2'd1, 1'b0, 32'h42, 64'h0000_BEEF, 1'b0, got);
        check("t2_sh_mem", mem_word(0, 16), 64'h1122_BEEF);
        do_txn(0, 1'b0, 2'd2, 1'b0, 32'h41, 64'd0, 1'b0, got);
        do_txn(0, 1'b1, 2'd1, 1'b0, 32'h43, 64'h0000_5555, 1'b0, got);
        do_txn(0, 1'b1, 2'd3, 1'b0, 32'h40, 64'h7777_7777, 1'b0, got);
        check("t3_mem", mem_word(0, 16), 64'h1122_BEEF);
        do_txn(1, 1'b0, 2'd1, 1'b0, 32'h40, 64'd0, 1'b0, got); check("t4_lhu", got, 64'h0000_FFEE);
        do_txn(1, 1'b0, 2'd1, 1'b1, 32'h40, 64'd0, 1'b0, got); check("t4_lh", got, 64'hFFFF_FFEE);

        // Reset in the middle of a sub-word store's read phase.
        @(negedge clk);
        rv[1] = 1'b1; rw[1] = 1'b1; rsz[1] = 2'd0; raddr[1] = 32'h45; rwd[1] = 64'hAA;
        @(posedge clk); #1;
        rv[1] = 1'b0;
        check("t5_in_read", 64'({bsy[1], mwe[1]}), 64'(2'b10));
        #2 rst_b = 1'b0;
        #1 check("t5_abort", 64'({bsy[1], rr[1], mwe[1]}), 64'(3'b010));
        @(negedge clk); rst_b = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mwe[1]) pulses++;
        end
        check("t5_no_write", 64'(pulses), 64'd0);
        check("t5_mem", mem_word(1, 17), model_word(1, 17));
        check("t5_idle", 64'({rr[1], bsy[1], respv[1]}), 64'(3'b100));

        // Back-to-back with req_valid held across the store's response.
        do_txn(2, 1'b1, 2'd2, 1'b0, 32'h10, 64'h0123_4567_89AB_CDEF, 1'b1, got);
        rw[2] = 1'b0; rsz[2] = 2'd2; rsg[2] = 1'b0; raddr[2] = 32'h10;
        @(posedge clk); #1;
        check("t6_idle", 64'(rr[2]), 64'd1);
        @(posedge clk); #1;
        check("t6_accept", 64'(bsy[2]), 64'd1);
        cyc = 1;
        while (!respv[2] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        rv[2] = 1'b0;
        check("t6_lat", 64'(cyc), 64'(lat_of(2) + 1));
        check("t6_lw", rdata[2], 64'h0123_4567_89AB_CDEF);

        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 40; i++)
                do_txn(d, 1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
                       {$urandom, $urandom}, 1'b0, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
